mnist_dlayer1_feeder: RTL and testbench

Input-side feeder for the layer-1 dense node. Accepts a word-serial activation stream over a valid/ready handshake and packs it into a double-buffered WORDS×DW-bit vector. When a frame is complete, it presents the vector to the node's `a` input with a one-cycle `valid` pulse. A credit counter, decremented by the node's `v_out`, bounds the number of frames in flight through the node pipeline.

---
 rtl/mnist_dlayer1_feeder.sv | 129 ++++++++++++
 tb/tb_mnist_dlayer1_feeder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_dlayer1_feeder.sv
// Packs a word-serial activation stream into a WORDS*DW vector for the layer-1
// dense node, issuing one valid pulse per frame under a credit limit.
module mnist_dlayer1_feeder #(
  parameter int WORDS   = 256,
  parameter int DW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DW-1:0]                    s_data,
  input  logic                             s_last,
  output logic [WORDS*DW-1:0]              a_out,
  output logic                             valid_out,
  input  logic                             node_done,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
  output logic                             err_short,
  output logic                             err_long,
  output logic                             err_underflow,
  output logic                             dbg_state_o
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WORDS*DW-1:0] load_q;
  logic [WORDS*DW-1:0] a_out_q;
  logic                valid_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                err_uf_q, err_uf_d;

  logic xfer;
  logic at_end;
  logic credit;
  logic issue;

  // Handshake: a word moves on any rising edge where s_valid && s_ready; s_ready
  // depends only on state, and s_valid may be held high while s_ready is low.
  assign xfer   = s_valid && s_ready;
  assign at_end = (idx_q == IW'(WORDS - 1));
  // A node_done in the same cycle frees a slot for an issue on that edge.
  assign credit = (cnt_q < CW'(MAX_OUT)) || node_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (xfer && at_end) state_d = S_FULL;
      S_FULL:  if (credit)         state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    s_ready = (state_q == S_FILL);
    issue   = (state_q == S_FULL) && credit;
  end

  always_comb begin
    idx_d = idx_q;
    if (xfer) begin
      if (at_end || s_last) idx_d = '0;
      else                  idx_d = idx_q + IW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !node_done)                        cnt_d = cnt_q + CW'(1);
    else if (!issue && node_done && (cnt_q != '0))  cnt_d = cnt_q - CW'(1);
  end

  // Short and long are exclusive by construction: one needs !at_end, the other at_end.
  always_comb begin
    err_short_d = xfer && s_last && !at_end;
    err_long_d  = xfer && at_end && !s_last;
    err_uf_d    = node_done && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      a_out_q     <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_uf_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      valid_q     <= issue;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_uf_q    <= err_uf_d;
      if (issue) a_out_q <= load_q;
    end
  end

  // Load buffer needs no reset; a frame is only issued after all words are rewritten.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (xfer && (idx_q == IW'(k))) load_q[k*DW +: DW] <= s_data;
    end
  end

  assign a_out         = a_out_q;
  assign valid_out     = valid_q;
  assign outstanding   = cnt_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign err_underflow = err_uf_q;
  assign dbg_state_o   = (state_q == S_FULL);

endmodule

// File: tb/tb_mnist_dlayer1_feeder.sv
// Bench for mnist_dlayer1_feeder: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mnist_dlayer1_feeder;

  localparam int WORDS   = 256;
  localparam int DW      = 32;
  localparam int MAX_OUT = 2;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_last;
  logic [WORDS*DW-1:0]  a_out;
  logic                 valid_out;
  logic                 node_done;
  logic [CW-1:0]        outstanding;
  logic                 err_short;
  logic                 err_long;
  logic                 err_underflow;
  logic                 dbg_state;

  mnist_dlayer1_feeder #(.WORDS(WORDS), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .a_out        (a_out),
    .valid_out    (valid_out),
    .node_done    (node_done),
    .outstanding  (outstanding),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_underflow(err_underflow),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string nm, input logic [WORDS*DW-1:0] act,
                           input logic [WORDS*DW-1:0] exp);
    int bad;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int k = WORDS - 1; k >= 0; k--)
        if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
      $display("FAIL %s: word %0d got %0h expected %0h (cycle %0d)", nm, bad,
               act[bad*DW +: DW], exp[bad*DW +: DW], cyc);
    end
  endtask

  // ---------------- node return path ----------------
  logic       auto_done;
  logic       man_done;
  logic [6:0] dl;
  always @(negedge clk) dl = {dl[5:0], valid_out};
  assign node_done = man_done | (auto_done & dl[6]);

  // ---------------- reference model ----------------
  logic [DW-1:0]       m_words[$];
  logic [WORDS*DW-1:0] m_pending;
  logic [WORDS*DW-1:0] m_aout;
  bit                  m_full;
  bit                  m_valid, m_es, m_el, m_eu;
  int                  m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_aout  = '0;
      m_full  = 0;
      m_valid = 0;
      m_es    = 0;
      m_el    = 0;
      m_eu    = 0;
      m_cnt   = 0;
    end else begin
      bit iss;
      iss     = m_full && (m_cnt < MAX_OUT || node_done);
      m_valid = iss;
      m_es    = 0;
      m_el    = 0;
      m_eu    = node_done && (m_cnt == 0);
      if (!m_full && s_valid) begin
        m_words.push_back(s_data);
        if (m_words.size() == WORDS) begin
          for (int k = 0; k < WORDS; k++) m_pending[k*DW +: DW] = m_words[k];
          m_full = 1;
          m_el   = !s_last;
          m_words.delete();
        end else if (s_last) begin
          m_es = 1;
          m_words.delete();
        end
      end else if (iss) begin
        m_aout = m_pending;
        m_full = 0;
      end
      if (iss && !node_done)                   m_cnt = m_cnt + 1;
      else if (!iss && node_done && m_cnt > 0) m_cnt = m_cnt - 1;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  int n_valid = 0;
  int last_v  = 0;
  int prev_v  = 0;

  always @(negedge clk) begin
    check("s_ready", s_ready, !m_full);
    check("dbg_state", dbg_state, m_full);
    check("valid_out", valid_out, m_valid);
    check("outstanding", outstanding, m_cnt);
    check("err_short", err_short, m_es);
    check("err_long", err_long, m_el);
    check("err_underflow", err_underflow, m_eu);
    check_vec("a_out", a_out, m_aout);
    if (valid_out) begin
      n_valid++;
      prev_v = last_v;
      last_v = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  int last_acc = 0;

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // Called in the phase just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept();
    int  t;
    bit  acc;
    t   = 0;
    acc = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      sync();
      t++;
      if (!acc && t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: no s_ready within 2000 cycles (cycle %0d)", cyc);
        acc = 1;
      end
    end
    last_acc = cyc;
  endtask

  task automatic send_frame(input int n, input bit last_end, input int base);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = DW'(base + k);
      s_last  = last_end && (k == n - 1);
      wait_accept();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    int t;
    t = 0;
    while (n_valid < target && t < 600) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("valid_seen", n_valid >= target, 1);
    sync();
  endtask

  function automatic logic [DW-1:0] word_of(input logic [WORDS*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int nv0;
    int bad;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    auto_done = 1'b0;
    man_done  = 1'b0;
    dl        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_out", a_out == '0, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_valid", valid_out, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", s_ready, 1);
    sync();

    // Single frame, data = word index, node returns 7 cycles after valid.
    auto_done = 1'b1;
    nv0 = n_valid;
    send_frame(WORDS, 1, 0);
    wait_valid(nv0 + 1);
    check("single_latency", last_v - last_acc, 1);
    bad = 0;
    for (int k = 0; k < WORDS; k++) if (word_of(a_out, k) != DW'(k)) bad++;
    check("single_ramp_bad_words", bad, 0);
    check("single_outstanding_1", outstanding, 1);
    idle(15);
    check("single_outstanding_0", outstanding, 0);

    // Back-to-back frames with s_valid held high.
    nv0 = n_valid;
    send_frame(WORDS, 1, 1000);
    send_frame(WORDS, 1, 2000);
    check("b2b_aout_stable", word_of(a_out, 255), 1255);
    wait_valid(nv0 + 2);
    check("b2b_period", last_v - prev_v, 257);
    check("b2b_second_w0", word_of(a_out, 0), 2000);
    idle(20);

    // Credit stall: no returns, third frame must wait in FULL.
    auto_done = 1'b0;
    check("stall_start_cnt", outstanding, 0);
    send_frame(WORDS, 1, 32'h10000);
    send_frame(WORDS, 1, 32'h20000);
    send_frame(WORDS, 1, 32'h30000);
    idle(5);
    check("stall_ready_low", s_ready, 0);
    check("stall_cnt", outstanding, 2);
    check("stall_aout_held", word_of(a_out, 0), 32'h20000);
    man_done = 1'b1;
    sync();
    man_done = 1'b0;
    check("stall_issue_valid", valid_out, 1);
    check("stall_cnt_same", outstanding, 2);
    check("stall_aout_new", word_of(a_out, 7), 32'h30007);
    man_done = 1'b1;
    idle(2);
    man_done = 1'b0;
    check("stall_drained", outstanding, 0);

    // Short frame, then a clean frame, then a long frame.
    auto_done = 1'b1;
    nv0 = n_valid;
    send_frame(10, 1, 32'h40000);
    @(negedge clk);
    check("short_pulse", err_short, 1);
    sync();
    check("short_no_valid", n_valid, nv0);
    send_frame(WORDS, 1, 32'h50000);
    wait_valid(nv0 + 1);
    check("after_short_w0", word_of(a_out, 0), 32'h50000);
    check("after_short_w9", word_of(a_out, 9), 32'h50009);
    send_frame(WORDS, 0, 32'h60000);
    @(negedge clk);
    check("long_pulse", err_long, 1);
    sync();
    wait_valid(nv0 + 2);
    check("long_issued_w255", word_of(a_out, 255), 32'h600FF);
    idle(20);

    // Underflow, then simultaneous issue and return at outstanding=1.
    auto_done = 1'b0;
    man_done  = 1'b1;
    sync();
    man_done  = 1'b0;
    @(negedge clk);
    check("uf_pulse", err_underflow, 1);
    check("uf_cnt_zero", outstanding, 0);
    sync();
    send_frame(WORDS, 1, 32'h70000);
    idle(3);
    check("sim_cnt_1", outstanding, 1);
    send_frame(WORDS, 1, 32'h80000);
    man_done = 1'b1;
    sync();
    man_done = 1'b0;
    check("sim_valid", valid_out, 1);
    check("sim_cnt_held", outstanding, 1);
    man_done = 1'b1;
    sync();
    man_done = 1'b0;
    check("sim_drained", outstanding, 0);

    // Reset in the middle of a frame with a frame outstanding.
    send_frame(WORDS, 1, 32'hA0000);
    idle(3);
    send_frame(100, 0, 32'h90000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a_out", a_out == '0, 1);
    check("midrst_cnt", outstanding, 0);
    check("midrst_valid", valid_out, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", s_ready, 1);
    sync();
    auto_done = 1'b1;
    nv0 = n_valid;
    send_frame(WORDS, 1, 32'hB0000);
    wait_valid(nv0 + 1);
    check("midrst_fresh_w0", word_of(a_out, 0), 32'hB0000);
    check("midrst_fresh_w255", word_of(a_out, 255), 32'hB00FF);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
